// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read DMEM port between the core
// MEM stage (port 0) and the UART program loader (port 1), with a loader burst lock.
module dmem_port_arbiter #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req_valid,
    output logic          c_req_ready,
    input  logic [31:0]   c_req_addr,
    input  logic [3:0]    c_req_wmask,
    input  logic [31:0]   c_req_wdata,
    input  logic          l_req_valid,
    output logic          l_req_ready,
    input  logic [31:0]   l_req_addr,
    input  logic [3:0]    l_req_wmask,
    input  logic [31:0]   l_req_wdata,
    input  logic          l_lock,
    output logic          c_rsp_valid,
    output logic [31:0]   c_rsp_rdata,
    output logic          l_rsp_valid,
    output logic [31:0]   l_rsp_rdata,
    output logic          c_stall,
    output logic          dmem_en,
    output logic [3:0]    dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_din,
    input  logic [31:0]   dmem_dout,
    output logic          dbg_state
);

    // Handshake: a request transfers in any cycle where valid and ready are both
    // high; ready never depends on a response signal, and an ungranted requester
    // holds its request unchanged until it sees ready.

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    arb_state_t state, state_next;
    logic       last_grant;
    logic [1:0] rsp_pend;
    logic       grant_c, grant_l;
    logic       arb_open;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB;
            last_grant <= 1'b1;
            rsp_pend   <= 2'b00;
        end else begin
            state <= state_next;
            if (grant_c) begin
                last_grant <= 1'b0;
            end else if (grant_l) begin
                last_grant <= 1'b1;
            end
            rsp_pend <= {grant_l & ~|l_req_wmask, grant_c & ~|c_req_wmask};
        end
    end

    // Dropping l_lock while LOCKED reopens arbitration in that same cycle.
    assign arb_open = (state == ARB) || !l_lock;

    always_comb begin
        grant_c    = 1'b0;
        grant_l    = 1'b0;
        state_next = state;
        if (rst) begin
            if (arb_open) begin
                if (c_req_valid && l_req_valid) begin
                    grant_c = last_grant;
                    grant_l = ~last_grant;
                end else begin
                    grant_c = c_req_valid;
                    grant_l = l_req_valid;
                end
                state_next = (grant_l && l_lock) ? LOCKED : ARB;
            end else begin
                grant_l = l_req_valid;
            end
        end
    end

    always_comb begin
        dmem_en   = 1'b0;
        dmem_we   = 4'b0000;
        dmem_addr = '0;
        dmem_din  = 32'h0;
        if (grant_c) begin
            dmem_en   = 1'b1;
            dmem_we   = c_req_wmask;
            dmem_addr = c_req_addr[AW+1:2];
            dmem_din  = c_req_wdata;
        end else if (grant_l) begin
            dmem_en   = 1'b1;
            dmem_we   = l_req_wmask;
            dmem_addr = l_req_addr[AW+1:2];
            dmem_din  = l_req_wdata;
        end
    end

    assign c_req_ready = grant_c;
    assign l_req_ready = grant_l;
    assign c_stall     = rst & c_req_valid & ~grant_c;

    assign c_rsp_valid = rst & rsp_pend[0];
    assign l_rsp_valid = rst & rsp_pend[1];
    assign c_rsp_rdata = c_rsp_valid ? dmem_dout : 32'h0;
    assign l_rsp_rdata = l_rsp_valid ? dmem_dout : 32'h0;

    assign dbg_state = state;

    // Region decode happens upstream, so the outer and byte-offset address bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{c_req_addr[31:AW+2], c_req_addr[1:0],
                                l_req_addr[31:AW+2], l_req_addr[1:0]};

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous-read DMEM model.
module tb_dmem_port_arbiter;

    localparam int AW = 14;

    logic          clk;
    logic          rst;
    logic          c_req_valid, l_req_valid;
    logic          c_req_ready, l_req_ready;
    logic [31:0]   c_req_addr, l_req_addr;
    logic [3:0]    c_req_wmask, l_req_wmask;
    logic [31:0]   c_req_wdata, l_req_wdata;
    logic          l_lock;
    logic          c_rsp_valid, l_rsp_valid;
    logic [31:0]   c_rsp_rdata, l_rsp_rdata;
    logic          c_stall;
    logic          dmem_en;
    logic [3:0]    dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_din;
    logic [31:0]   dmem_dout;
    logic          dbg_state;

    int tests_run;
    int tests_failed;

    logic [31:0] mem [256];

    dmem_port_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
        .c_req_addr(c_req_addr), .c_req_wmask(c_req_wmask), .c_req_wdata(c_req_wdata),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready),
        .l_req_addr(l_req_addr), .l_req_wmask(l_req_wmask), .l_req_wdata(l_req_wdata),
        .l_lock(l_lock),
        .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
        .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata),
        .c_stall(c_stall),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM model: word i preloaded with 0xA000_0000 + i, one-cycle read latency
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        dmem_dout = 32'h0;
    end

    always @(posedge clk) begin
        if (dmem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_we[b]) mem[dmem_addr[7:0]][8*b +: 8] <= dmem_din[8*b +: 8];
            end
            dmem_dout <= mem[dmem_addr[7:0]];
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_req_valid = 1'b0; c_req_addr = 32'h0; c_req_wmask = 4'h0; c_req_wdata = 32'h0;
        l_req_valid = 1'b0; l_req_addr = 32'h0; l_req_wmask = 4'h0; l_req_wdata = 32'h0;
        l_lock = 1'b0;
    endtask

    task automatic test_reset();
        c_req_valid = 1'b1; c_req_wmask = 4'hF; c_req_addr = 32'h10;
        l_req_valid = 1'b1; l_req_wmask = 4'hF;
        @(negedge clk);
        tests_run++;
        if ({c_req_ready, l_req_ready, dmem_en, c_stall} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_forced: rdy_c/rdy_l/en/stall got %b want 0000",
                     {c_req_ready, l_req_ready, dmem_en, c_stall});
        end
        tests_run++;
        if (dmem_we !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_we: got %h want 0", dmem_we);
        end
        step();
        rst = 1'b1;
        idle();
        @(negedge clk);
        tests_run++;
        if ({dbg_state, c_rsp_valid, l_rsp_valid, c_rsp_rdata, l_rsp_rdata} !== 67'h0) begin
            tests_failed++;
            $display("FAIL reset_state: state=%b rv_c=%b rv_l=%b rd_c=%h rd_l=%h want all 0",
                     dbg_state, c_rsp_valid, l_rsp_valid, c_rsp_rdata, l_rsp_rdata);
        end
        step();
    endtask

    task automatic test_core_read();
        c_req_valid = 1'b1; c_req_addr = 32'h0000_0010; c_req_wmask = 4'h0;
        @(negedge clk);
        tests_run++;
        if ({c_req_ready, l_req_ready, dmem_en, dmem_we} !== 7'b1010000) begin
            tests_failed++;
            $display("FAIL core_read_grant: rdy_c=%b rdy_l=%b en=%b we=%h want 1 0 1 0",
                     c_req_ready, l_req_ready, dmem_en, dmem_we);
        end
        tests_run++;
        if (dmem_addr !== 14'd4) begin
            tests_failed++;
            $display("FAIL core_read_addr: got %0d want 4", dmem_addr);
        end
        step();
        // upper and byte-offset address bits are ignored
        c_req_addr = 32'hFFFF_0013;
        @(negedge clk);
        tests_run++;
        if ({c_rsp_valid, c_rsp_rdata, l_rsp_valid} !== {1'b1, 32'hA000_0004, 1'b0}) begin
            tests_failed++;
            $display("FAIL core_read_rsp: rv_c=%b rd_c=%h rv_l=%b want 1 a0000004 0",
                     c_rsp_valid, c_rsp_rdata, l_rsp_valid);
        end
        tests_run++;
        if (dmem_addr !== 14'd4) begin
            tests_failed++;
            $display("FAIL addr_ignore_bits: got %0d want 4", dmem_addr);
        end
        step();
        idle();
        @(negedge clk);
        tests_run++;
        if ({c_rsp_valid, c_rsp_rdata, dmem_en} !== {1'b1, 32'hA000_0004, 1'b0}) begin
            tests_failed++;
            $display("FAIL core_read_rsp2: rv_c=%b rd_c=%h en=%b want 1 a0000004 0",
                     c_rsp_valid, c_rsp_rdata, dmem_en);
        end
        step();
    endtask

    task automatic test_loader_write();
        l_req_valid = 1'b1; l_req_addr = 32'h20; l_req_wmask = 4'b0011; l_req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if ({l_req_ready, c_req_ready, dmem_we, dmem_addr, dmem_din} !==
            {1'b1, 1'b0, 4'b0011, 14'd8, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL ld_write: rdy_l=%b rdy_c=%b we=%b addr=%0d din=%h want 1 0 0011 8 deadbeef",
                     l_req_ready, c_req_ready, dmem_we, dmem_addr, dmem_din);
        end
        step();
        // read the same word straight back
        l_req_wmask = 4'h0; l_req_wdata = 32'h0;
        @(negedge clk);
        tests_run++;
        if ({c_rsp_valid, l_rsp_valid, c_rsp_rdata, l_rsp_rdata} !== 66'h0) begin
            tests_failed++;
            $display("FAIL ld_write_norsp: rv_c=%b rv_l=%b rd_c=%h rd_l=%h want 0 0 0 0",
                     c_rsp_valid, l_rsp_valid, c_rsp_rdata, l_rsp_rdata);
        end
        step();
        idle();
        @(negedge clk);
        tests_run++;
        if ({l_rsp_valid, l_rsp_rdata, c_rsp_valid} !== {1'b1, 32'hA000_BEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL ld_raw: rv_l=%b rd_l=%h rv_c=%b want 1 a000beef 0",
                     l_rsp_valid, l_rsp_rdata, c_rsp_valid);
        end
        step();
    endtask

    task automatic test_alternate();
        logic [31:0] exp_q[$];
        logic        prev_core;
        c_req_valid = 1'b1; c_req_addr = 32'h40; c_req_wmask = 4'h0;
        l_req_valid = 1'b1; l_req_addr = 32'h80; l_req_wmask = 4'h0;
        prev_core = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) idle();
            @(negedge clk);
            if (i < 4) begin
                tests_run++;
                if ({c_req_ready, l_req_ready, c_stall} !== {(i % 2 == 0), (i % 2 == 1), (i % 2 == 1)}) begin
                    tests_failed++;
                    $display("FAIL alt_grant[%0d]: rdy_c=%b rdy_l=%b stall=%b", i,
                             c_req_ready, l_req_ready, c_stall);
                end
            end
            if (i > 0) begin
                tests_run++;
                if ({c_rsp_valid, l_rsp_valid} !== {prev_core, ~prev_core} ||
                    (prev_core ? c_rsp_rdata : l_rsp_rdata) !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL alt_rsp[%0d]: rv_c=%b rv_l=%b rd_c=%h rd_l=%h want core=%b data %h",
                             i, c_rsp_valid, l_rsp_valid, c_rsp_rdata, l_rsp_rdata, prev_core, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            prev_core = (i % 2 == 0);
            exp_q.push_back(prev_core ? 32'hA000_0010 : 32'hA000_0020);
            step();
        end
    endtask

    task automatic test_lock();
        int core_rdy_seen;
        core_rdy_seen = 0;
        l_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_req_valid = (i > 0); c_req_addr = 32'h40;
            l_req_valid = (i < 3); l_req_addr = 32'h100 + 4 * i;
            l_req_wmask = 4'hF; l_req_wdata = i;
            @(negedge clk);
            if (c_req_ready) core_rdy_seen++;
            tests_run++;
            if ({l_req_ready, dmem_en} !== {(i < 3), (i < 3)}) begin
                tests_failed++;
                $display("FAIL lock_loader[%0d]: rdy_l=%b en=%b want %b", i, l_req_ready, dmem_en, (i < 3));
            end
            if (i > 0) begin
                tests_run++;
                if ({dbg_state, c_stall} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL lock_state[%0d]: state=%b stall=%b want 1 1", i, dbg_state, c_stall);
                end
            end
            step();
        end
        tests_run++;
        if (core_rdy_seen != 0) begin
            tests_failed++;
            $display("FAIL lock_core_held: core ready cycles %0d want 0", core_rdy_seen);
        end
        l_lock = 1'b0; l_req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({dbg_state, c_req_ready, c_stall, dmem_addr} !== {1'b1, 1'b1, 1'b0, 14'd16}) begin
            tests_failed++;
            $display("FAIL lock_release: state=%b rdy_c=%b stall=%b addr=%0d want 1 1 0 16",
                     dbg_state, c_req_ready, c_stall, dmem_addr);
        end
        step();
        idle();
        @(negedge clk);
        tests_run++;
        if ({dbg_state, c_rsp_valid, c_rsp_rdata} !== {1'b0, 1'b1, 32'hA000_0010}) begin
            tests_failed++;
            $display("FAIL lock_after: state=%b rv_c=%b rd_c=%h want 0 1 a0000010",
                     dbg_state, c_rsp_valid, c_rsp_rdata);
        end
        step();
        // confirm the locked burst landed in memory
        l_req_valid = 1'b1; l_req_addr = 32'h108; l_req_wmask = 4'h0;
        step();
        idle();
        @(negedge clk);
        tests_run++;
        if ({l_rsp_valid, l_rsp_rdata} !== {1'b1, 32'h0000_0002}) begin
            tests_failed++;
            $display("FAIL lock_burst_data: rv_l=%b rd_l=%h want 1 00000002", l_rsp_valid, l_rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_locked();
        l_lock = 1'b1; l_req_valid = 1'b1; l_req_addr = 32'h0; l_req_wmask = 4'h0;
        step();
        l_req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({l_rsp_valid, l_req_ready, dbg_state} !== 3'b001) begin
            tests_failed++;
            $display("FAIL rst_lock_pre: rv_l=%b rdy_l=%b state=%b want 0 0 1",
                     l_rsp_valid, l_req_ready, dbg_state);
        end
        step();
        rst = 1'b1; l_lock = 1'b0;
        c_req_valid = 1'b1; c_req_addr = 32'h4; c_req_wmask = 4'h0;
        l_req_valid = 1'b1; l_req_addr = 32'h8; l_req_wmask = 4'h0;
        @(negedge clk);
        tests_run++;
        if ({dbg_state, c_rsp_valid, l_rsp_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_lock_post: state=%b rv_c=%b rv_l=%b want 0 0 0",
                     dbg_state, c_rsp_valid, l_rsp_valid);
        end
        tests_run++;
        if ({c_req_ready, l_req_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_first_tie: rdy_c=%b rdy_l=%b want 1 0", c_req_ready, l_req_ready);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        int grants, rsps;
        grants = 0; rsps = 0;
        for (int i = 0; i < 10; i++) begin
            c_req_valid = (i < 8); c_req_addr = 4 * i; c_req_wmask = 4'h0;
            @(negedge clk);
            if (c_req_ready && dmem_en && dmem_addr == i) grants++;
            if (i > 0 && i < 9) begin
                tests_run++;
                if ({c_rsp_valid, c_rsp_rdata} !== {1'b1, 32'hA000_0000 + i - 1}) begin
                    tests_failed++;
                    $display("FAIL b2b_rsp[%0d]: rv_c=%b rd_c=%h want 1 %h", i,
                             c_rsp_valid, c_rsp_rdata, 32'hA000_0000 + i - 1);
                end
            end
            if (c_rsp_valid) rsps++;
            step();
        end
        tests_run++;
        if (grants != 8 || rsps != 8) begin
            tests_failed++;
            $display("FAIL b2b_counts: grants=%0d rsps=%0d want 8 8", grants, rsps);
        end
        idle();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_core_read();
        test_loader_write();
        test_alternate();
        test_lock();
        test_reset_locked();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single synchronous-read data-memory port between two requesters: the core MEM stage (port 0) and the UART program loader (port 1). It arbitrates round-robin, supports a loader burst lock, and drives the DMEM enable, write mask, address and write data. It routes the one-cycle-latency read data back to the requester that issued the read. It sits between the core's memory stage and the DMEM block, beside the writeback selection logic, which consumes `c_rsp_rdata` when the DMEM read path is selected.

## Interface
- `AW`, default 14: DMEM word-index width; DMEM address = `req_addr[AW+1:2]`.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low; asserted while `rst == 0`.
- `c_req_valid`, `l_req_valid` input 1: core / loader request valid.
- `c_req_ready`, `l_req_ready` output 1: request accepted this cycle (valid & ready = handshake).
- `c_req_addr`, `l_req_addr` input 32: byte address.
- `c_req_wmask`, `l_req_wmask` input 4: byte write mask; `4'b0000` = read.
- `c_req_wdata`, `l_req_wdata` input 32: write data, pre-aligned by the requester.
- `l_lock` input 1: loader burst lock.
- `c_rsp_valid`, `l_rsp_valid` output 1: read data valid for that port.
- `c_rsp_rdata`, `l_rsp_rdata` output 32: read data.
- `c_stall` output 1: `c_req_valid & ~c_req_ready`; feeds the core stall logic.
- `dmem_en` output 1: DMEM access this cycle.
- `dmem_we` output 4: DMEM byte write enables.
- `dmem_addr` output AW: DMEM word address.
- `dmem_din` output 32: DMEM write data.
- `dmem_dout` input 32: DMEM read data, valid the cycle after an enabled read.

## Operation
- Registered state:
  - `last_grant`: 0 = core, 1 = loader.
  - `state`: ARB or LOCKED.
  - `rsp_pend[1:0]`: one-hot record of a read issued last cycle.
- ARB arbitration:
  - Only one requester valid → that requester is granted.
  - Both valid → grant goes to the port that is not `last_grant`.
  - Neither valid → no grant, `dmem_en = 0`.
- Grant actions, all combinational in the grant cycle:
  - Assert the granted port's `*_req_ready`.
  - `dmem_en = 1`.
  - Drive `dmem_we`, `dmem_addr`, `dmem_din` from the granted port.
  - Ungranted port's ready = 0.
- On a granted handshake, `last_grant` ← granted port.
- ARB → LOCKED: loader granted with `l_lock = 1`.
- In LOCKED:
  - Only the loader may be granted; core ready is held at 0.
  - A cycle with `l_req_valid = 0` grants nothing; it does not release the lock.
  - LOCKED → ARB when `l_lock = 0` is sampled; that same cycle is arbitrated as in ARB.
- Read response routing:
  - A granted read (`wmask == 0`) sets the matching `rsp_pend` bit for exactly one cycle.
  - Next cycle: `*_rsp_valid = rsp_pend[port]`, `*_rsp_rdata = dmem_dout`.
  - Writes produce no response.
  - Non-pending port's rdata is 0.
- Back-to-back grants are legal every cycle, so throughput is one access per cycle.
- Requests that are valid but not granted are held by the requester unchanged; the arbiter does not latch them.

## Timing
- Reset (`rst == 0` at an edge) sets:
  - `state` = ARB, `last_grant` = 1 (core wins the first tie), `rsp_pend` = 0.
  - While `rst == 0`, all readies, `dmem_en`, `dmem_we` and `c_stall` are forced 0.
  - `rsp_valid` outputs = 0; `rdata` = 0.
- Reset mid-burst drops the lock. A read issued in the cycle before reset returns no response.
- Read latency: handshake in cycle N → `rsp_valid` in cycle N+1, in the same cycle as `dmem_dout`.
- Ready depends combinationally on both valids, `state` and `l_lock`, and on no response signal.
- A write and a read to the same address in consecutive cycles: the read returns the newly written data (DMEM is read-after-write on separate cycles).
- Simultaneous core read response and loader grant in the same cycle is legal: the response path is independent of the request path.
- Address bits `[31:AW+2]` and `[1:0]` are ignored; region decode is upstream.

## Test plan
- Reset, then `c_req_valid = 1`, read at `0x0000_0010` → `c_req_ready = 1`, `dmem_addr = 4` in the same cycle. Next cycle `c_rsp_valid = 1` with `c_rsp_rdata = dmem_dout`; `l_rsp_valid = 0`.
- Both ports valid for 4 cycles, reads → grants alternate core, loader, core, loader. `c_stall` = 0,1,0,1. Each response returns on the correct port one cycle later.
- Loader writes `wmask = 4'b0011`, `wdata = 0xDEAD_BEEF`, `addr = 0x20` → `dmem_we = 4'b0011`, `dmem_addr = 8`. No `rsp_valid` on either port next cycle.
- `l_lock = 1` with 3 loader writes while the core is valid, then a 1-cycle loader bubble with lock still high → core ready stays 0 throughout. After `l_lock` drops, the core is granted in that same cycle.
- Assert reset during LOCKED with a read pending → next cycle `rsp_valid = 0` on both ports and `state` = ARB. First tie after release goes to the core.
- Core reads back-to-back every cycle for 8 cycles with the loader idle → 8 consecutive grants and 8 responses, each exactly one cycle after its handshake.
